// File: rtl/sonic_pkg.sv
// Shared constants for the ultrasonic Trig/Echo emulator and its receiver-side distance math.
package sonic_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_TRIG_HI  = 3'd1;
    localparam logic [2:0] ST_HOLDOFF  = 3'd2;
    localparam logic [2:0] ST_ECHO     = 3'd3;
    localparam logic [2:0] ST_COOLDOWN = 3'd4;

    // echo_us = cm * CM_NUM / CM_DEN; the receiver inverts the same ratio
    localparam int CM_NUM = 1000;
    localparam int CM_DEN = 17;

    localparam int DEF_TICK_DIV     = 100;
    localparam int DEF_MIN_TRIG_CYC = 1000;
    localparam int DEF_HOLDOFF_US   = 500;
    localparam int DEF_MAX_CM       = 400;
    localparam int DEF_TIMEOUT_US   = 38000;
    localparam int DEF_COOLDOWN_US  = 1000;

    localparam int DIV_W   = 30;
    localparam int DIVR_W  = 5;
    localparam int DIV_LAT = DIV_W + 2;

    function automatic logic [DIV_W-1:0] cm_to_dividend(input logic [19:0] cm);
        return DIV_W'(cm) * DIV_W'(CM_NUM);
    endfunction

    function automatic logic [15:0] sat_u16(input logic [DIV_W-1:0] v);
        return (v > DIV_W'(16'hFFFF)) ? 16'hFFFF : v[15:0];
    endfunction

endpackage

// File: rtl/sonic_echo_emu_seq_div.sv
// Restoring divider, one quotient bit per cycle: done pulses DW+1 cycles after start.
// No backpressure; quotient holds until the next start, a start mid-run restarts.
module seq_div #(
    parameter int DW = 30,
    parameter int VW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic [DW-1:0] quotient,
    output logic          done
);
    localparam int CW = $clog2(DW);

    logic [DW-1:0] dq_q, dq_d;
    logic [VW-1:0] rem_q, rem_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          run_q, run_d;
    logic          done_q, done_d;
    logic [VW:0]   rem_sh;
    logic          ge;

    // dq holds the unconsumed dividend bits on the left and the quotient filling in from the right
    always_comb begin
        rem_sh = {rem_q, dq_q[DW-1]};
        ge     = rem_sh >= {1'b0, divisor};
        dq_d   = dq_q;
        rem_d  = rem_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        done_d = 1'b0;
        if (start) begin
            dq_d  = dividend;
            rem_d = '0;
            cnt_d = '0;
            run_d = 1'b1;
        end else if (run_q) begin
            rem_d = ge ? VW'(rem_sh - {1'b0, divisor}) : rem_sh[VW-1:0];
            dq_d  = {dq_q[DW-2:0], ge};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(DW-1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dq_q   <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            dq_q   <= dq_d;
            rem_q  <= rem_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign quotient = dq_q;
    assign done     = done_q;

endmodule

// File: rtl/sonic_echo_emu.sv
// Device end of the Trig/Echo ranging protocol: echo rises HOLDOFF after trig falls, width encodes dist_cm.
// Latency fixed by the timing parameters; no backpressure, triggers while busy are dropped.
module sonic_echo_emu
    import sonic_pkg::*;
#(
    parameter int TICK_DIV     = DEF_TICK_DIV,
    parameter int MIN_TRIG_CYC = DEF_MIN_TRIG_CYC,
    parameter int HOLDOFF_US   = DEF_HOLDOFF_US,
    parameter int MAX_CM       = DEF_MAX_CM,
    parameter int TIMEOUT_US   = DEF_TIMEOUT_US,
    parameter int COOLDOWN_US  = DEF_COOLDOWN_US
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trig,
    input  logic [19:0] dist_cm,
    output logic        echo,
    output logic        busy,
    output logic        trig_err
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int WW = $clog2(MIN_TRIG_CYC + 1);

    if (HOLDOFF_US * TICK_DIV <= DIV_LAT) begin : g_bad_holdoff
        $error("holdoff window shorter than divider latency");
    end
    if (TICK_DIV < 2) begin : g_bad_tick
        $error("TICK_DIV must be at least 2");
    end

    logic              trig_m_q, trig_m_d, trig_s_q, trig_s_d, trig_prev_q, trig_prev_d;
    logic [2:0]        state_q, state_d;
    logic [WW-1:0]     width_q, width_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [15:0]       us_q, us_d;
    logic [19:0]       dist_q, dist_d;
    logic [15:0]       echo_us_q, echo_us_d;
    logic              echo_q, echo_d, busy_q, busy_d, err_q, err_d;
    logic              rise, fall, tick_end, div_start, div_done;
    logic [DIV_W-1:0]  div_dividend, div_quo;

    assign div_dividend = cm_to_dividend(dist_cm);

    seq_div #(.DW(DIV_W), .VW(DIVR_W)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (DIVR_W'(CM_DEN)),
        .quotient (div_quo),
        .done     (div_done)
    );

    always_comb begin
        trig_m_d    = trig;
        trig_s_d    = trig_m_q;
        trig_prev_d = trig_s_q;
        rise        = trig_s_q & ~trig_prev_q;
        fall        = ~trig_s_q & trig_prev_q;
        tick_end    = presc_q == PW'(TICK_DIV - 1);
        state_d     = state_q;
        width_d     = width_q;
        presc_d     = tick_end ? '0 : presc_q + 1'b1;
        us_d        = tick_end ? us_q + 16'd1 : us_q;
        dist_d      = dist_q;
        echo_us_d   = echo_us_q;
        err_d       = 1'b0;
        div_start   = 1'b0;
        if (div_done) begin
            echo_us_d = (dist_q == '0 || dist_q > 20'(MAX_CM)) ? 16'(TIMEOUT_US) : sat_u16(div_quo);
        end
        case (state_q)
            ST_IDLE: begin
                presc_d = '0;
                us_d    = '0;
                width_d = rise ? WW'(1) : '0;
                if (rise) state_d = ST_TRIG_HI;
            end
            ST_TRIG_HI: begin
                presc_d = '0;
                us_d    = '0;
                if (fall) begin
                    if (width_q >= WW'(MIN_TRIG_CYC)) begin
                        dist_d    = dist_cm;
                        div_start = 1'b1;
                        state_d   = ST_HOLDOFF;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (trig_s_q && width_q < WW'(MIN_TRIG_CYC)) begin
                    width_d = width_q + 1'b1;
                end
            end
            // the fall-detect cycle already counts as the first holdoff cycle
            ST_HOLDOFF: if (us_q == 16'(HOLDOFF_US - 1) && presc_q == PW'(TICK_DIV - 2)) state_d = ST_ECHO;
            ST_ECHO:    if (us_q == echo_us_q - 16'd1 && tick_end) state_d = ST_COOLDOWN;
            ST_COOLDOWN: begin
                if (us_q == 16'(COOLDOWN_US - 1) && tick_end) begin
                    state_d = ST_IDLE;
                    width_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_d != state_q) begin
            presc_d = '0;
            us_d    = '0;
        end
        echo_d = state_d == ST_ECHO;
        busy_d = state_d == ST_HOLDOFF || state_d == ST_ECHO || state_d == ST_COOLDOWN;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trig_m_q    <= 1'b0;
            trig_s_q    <= 1'b0;
            trig_prev_q <= 1'b0;
            state_q     <= ST_IDLE;
            width_q     <= '0;
            presc_q     <= '0;
            us_q        <= '0;
            dist_q      <= '0;
            echo_us_q   <= '0;
            echo_q      <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            trig_m_q    <= trig_m_d;
            trig_s_q    <= trig_s_d;
            trig_prev_q <= trig_prev_d;
            state_q     <= state_d;
            width_q     <= width_d;
            presc_q     <= presc_d;
            us_q        <= us_d;
            dist_q      <= dist_d;
            echo_us_q   <= echo_us_d;
            echo_q      <= echo_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign echo     = echo_q;
    assign busy     = busy_q;
    assign trig_err = err_q;

endmodule

// File: tb/tb_sonic_echo_emu.sv
// Directed bench for sonic_echo_emu with timing scaled down (2 clk per us) to keep runs short.
module tb_sonic_echo_emu;
    import sonic_pkg::*;

    localparam int TD   = 2;
    localparam int MINC = 20;
    localparam int HO   = 40;
    localparam int MAXC = 400;
    localparam int TO   = 3000;
    localparam int CD   = 50;
    // trig release to first echo sample: two synchronizer stages plus the holdoff
    localparam int LAT_EXP  = HO * TD + 2;
    localparam int COOL_EXP = CD * TD;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        trig = 1'b0;
    logic [19:0] dist_cm = '0;
    logic        echo, busy, trig_err;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    sonic_echo_emu #(
        .TICK_DIV(TD), .MIN_TRIG_CYC(MINC), .HOLDOFF_US(HO),
        .MAX_CM(MAXC), .TIMEOUT_US(TO), .COOLDOWN_US(CD)
    ) dut (
        .clk(clk), .rst(rst), .trig(trig), .dist_cm(dist_cm),
        .echo(echo), .busy(busy), .trig_err(trig_err)
    );

    task automatic measure_from_release(output int lat, output int wid, output int cool);
        int n;
        trig = 1'b0;
        lat = -1; wid = -1; cool = -1;
        n = 0;
        while (lat < 0 && n < 2000) begin
            @(negedge clk); n++;
            if (echo) lat = n;
        end
        if (lat < 0) return;
        n = 1;
        while (n < 20000) begin
            @(negedge clk);
            if (!echo) break;
            n++;
        end
        if (echo) return;
        wid = n;
        n = 0;
        while (busy && n < 2000) begin
            @(negedge clk); n++;
        end
        if (!busy) cool = n;
    endtask

    task automatic run_meas(input int hi_cyc, input logic [19:0] d,
                            output int lat, output int wid, output int cool);
        dist_cm = d;
        @(negedge clk);
        trig = 1'b1;
        repeat (hi_cyc) @(negedge clk);
        measure_from_release(lat, wid, cool);
    endtask

    task automatic wait_echo_high(output int ok);
        int n;
        n = 0;
        while (!echo && n < 2000) begin
            @(negedge clk); n++;
        end
        ok = echo ? 1 : 0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (echo !== 1'b0) begin errors++; $display("FAIL reset_echo got %b exp 0", echo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (trig_err !== 1'b0) begin errors++; $display("FAIL reset_trig_err got %b exp 0", trig_err); end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %b exp 0", busy); end
    endtask

    task automatic test_dist100();
        int lat, wid, cool, rx;
        run_meas(MINC, 20'd100, lat, wid, cool);
        rx = (wid / TD) * CM_DEN / CM_NUM;
        checks++; if (lat !== LAT_EXP) begin errors++; $display("FAIL d100_latency got %0d exp %0d", lat, LAT_EXP); end
        checks++; if (wid !== 11764) begin errors++; $display("FAIL d100_width got %0d exp 11764", wid); end
        checks++; if (cool !== COOL_EXP) begin errors++; $display("FAIL d100_cooldown got %0d exp %0d", cool, COOL_EXP); end
        checks++; if (rx !== 99) begin errors++; $display("FAIL d100_receiver_cm got %0d exp 99", rx); end
    endtask

    task automatic test_out_of_range();
        int lat, wid, cool;
        run_meas(MINC, 20'd0, lat, wid, cool);
        checks++; if (wid !== 6000) begin errors++; $display("FAIL d0_width got %0d exp 6000", wid); end
        checks++; if (cool !== COOL_EXP) begin errors++; $display("FAIL d0_cooldown got %0d exp %0d", cool, COOL_EXP); end
        run_meas(MINC, 20'd401, lat, wid, cool);
        checks++; if (wid !== 6000) begin errors++; $display("FAIL d401_width got %0d exp 6000", wid); end
        checks++; if (cool !== COOL_EXP) begin errors++; $display("FAIL d401_cooldown got %0d exp %0d", cool, COOL_EXP); end
        run_meas(MINC, 20'd1, lat, wid, cool);
        checks++; if (wid !== 116) begin errors++; $display("FAIL d1_width got %0d exp 116", wid); end
        checks++; if (lat !== LAT_EXP) begin errors++; $display("FAIL d1_latency got %0d exp %0d", lat, LAT_EXP); end
    endtask

    task automatic test_short_trig();
        int errs, echo_hi, busy_hi, lat, wid, cool;
        errs = 0; echo_hi = 0; busy_hi = 0;
        dist_cm = 20'd100;
        @(negedge clk);
        trig = 1'b1;
        repeat (MINC - 1) @(negedge clk);
        trig = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (trig_err) errs++;
            if (echo) echo_hi++;
            if (busy) busy_hi++;
        end
        checks++; if (errs !== 1) begin errors++; $display("FAIL short_trig_err_pulses got %0d exp 1", errs); end
        checks++; if (echo_hi !== 0) begin errors++; $display("FAIL short_trig_echo got %0d exp 0", echo_hi); end
        checks++; if (busy_hi !== 0) begin errors++; $display("FAIL short_trig_busy got %0d exp 0", busy_hi); end
        run_meas(MINC, 20'd20, lat, wid, cool);
        checks++; if (wid !== 2352) begin errors++; $display("FAIL after_short_width got %0d exp 2352", wid); end
    endtask

    task automatic test_back_to_back();
        int ok, n, errs, extra, lat, wid, cool;
        errs = 0; extra = 0;
        dist_cm = 20'd100;
        @(negedge clk);
        trig = 1'b1;
        repeat (MINC) @(negedge clk);
        trig = 1'b0;
        wait_echo_high(ok);
        checks++; if (ok !== 1) begin errors++; $display("FAIL b2b_echo_rise got %0d exp 1", ok); end
        if (ok != 1) return;
        n = 1;
        while (n < 20000) begin
            @(negedge clk);
            if (trig_err) errs++;
            if (n == 100) trig = 1'b1;
            if (n == 100 + MINC) trig = 1'b0;
            if (n == 300) dist_cm = 20'd20;
            if (!echo) break;
            n++;
        end
        trig = 1'b0;
        checks++; if (n !== 11764) begin errors++; $display("FAIL b2b_width got %0d exp 11764", n); end
        n = 0;
        while (busy && n < 2000) begin
            @(negedge clk); n++;
            if (echo) extra++;
            if (trig_err) errs++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL b2b_extra_echo got %0d exp 0", extra); end
        checks++; if (errs !== 0) begin errors++; $display("FAIL b2b_trig_err got %0d exp 0", errs); end
        run_meas(MINC, 20'd20, lat, wid, cool);
        checks++; if (wid !== 2352) begin errors++; $display("FAIL b2b_next_width got %0d exp 2352", wid); end
    endtask

    task automatic test_reset_mid_echo();
        int ok, lat, wid, cool;
        dist_cm = 20'd100;
        @(negedge clk);
        trig = 1'b1;
        repeat (MINC) @(negedge clk);
        trig = 1'b0;
        wait_echo_high(ok);
        checks++; if (ok !== 1) begin errors++; $display("FAIL rst_mid_echo_rise got %0d exp 1", ok); end
        repeat (200) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        checks++; if (echo !== 1'b0) begin errors++; $display("FAIL rst_mid_echo got %b exp 0", echo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", busy); end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        run_meas(MINC, 20'd30, lat, wid, cool);
        checks++; if (lat !== LAT_EXP) begin errors++; $display("FAIL post_rst_latency got %0d exp %0d", lat, LAT_EXP); end
        checks++; if (wid !== 3528) begin errors++; $display("FAIL post_rst_width got %0d exp 3528", wid); end
    endtask

    task automatic test_trig_held();
        int lat, wid, cool;
        dist_cm = 20'd0;
        @(negedge clk);
        trig = 1'b1;
        repeat (200) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL held_busy got %b exp 0", busy); end
        dist_cm = 20'd30;
        measure_from_release(lat, wid, cool);
        checks++; if (lat !== LAT_EXP) begin errors++; $display("FAIL held_latency got %0d exp %0d", lat, LAT_EXP); end
        checks++; if (wid !== 3528) begin errors++; $display("FAIL held_width got %0d exp 3528", wid); end
        checks++; if (cool !== COOL_EXP) begin errors++; $display("FAIL held_cooldown got %0d exp %0d", cool, COOL_EXP); end
    endtask

    initial begin
        test_reset();
        test_dist100();
        test_out_of_range();
        test_short_trig();
        test_back_to_back();
        test_reset_mid_echo();
        test_trig_held();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
